// File: rtl/bus_fifo_pkg.sv
// bus_fifo_pkg: shared defaults for the bus_fifo word queue
package bus_fifo_pkg;
  localparam int FIFO_WIDTH = 8;
  localparam int FIFO_DEPTH = 4;
endpackage

// File: rtl/bus_fifo_cell.sv
// bus_fifo_cell: one storage word, load-strobed register without reset
// Ports: clock, load (write enable), in (data), out (stored word).
module bus_fifo_cell import bus_fifo_pkg::*; #(
  parameter int BUS_WIDTH = FIFO_WIDTH
) (
  input  logic                 clock,
  input  logic                 load,
  input  logic [BUS_WIDTH-1:0] in,
  output logic [BUS_WIDTH-1:0] out
);
  always_ff @(posedge clock)
    if (load) out <= in;
endmodule

// File: rtl/bus_fifo.sv
// bus_fifo: first-word-fall-through queue with load/read strobes and error pulses
// Ports: clock, reset (async, active-high), in/load (write side),
//   read (pop), out (head word, 0 when empty), empty, full, count,
//   overflow/underflow (one-cycle pulses after a rejected write/read).
module bus_fifo import bus_fifo_pkg::*; #(
  parameter int BUS_WIDTH = FIFO_WIDTH,
  parameter int DEPTH     = FIFO_DEPTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [BUS_WIDTH-1:0]     in,
  input  logic                     load,
  input  logic                     read,
  output logic [BUS_WIDTH-1:0]     out,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);
  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);
  logic [ADDR_WIDTH-1:0] wptr, rptr;
  logic [BUS_WIDTH-1:0]  mem [DEPTH];
  logic                  wr_ok, rd_ok;
  assign empty = count == '0;
  assign full  = count == FULL_COUNT;
  // a pop in the same edge frees the slot a write into a full queue needs
  assign wr_ok = load && (!full || read);
  assign rd_ok = read && !empty;
  assign out   = empty ? '0 : mem[rptr];
  for (genvar i = 0; i < DEPTH; i++) begin : g_mem
    bus_fifo_cell #(.BUS_WIDTH(BUS_WIDTH)) u_cell (
      .clock(clock),
      .load (wr_ok && wptr == ADDR_WIDTH'(i)),
      .in   (in),
      .out  (mem[i])
    );
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) rptr <= rptr + 1'b1;
      count     <= count + (ADDR_WIDTH+1)'(wr_ok) - (ADDR_WIDTH+1)'(rd_ok);
      overflow  <= load && !wr_ok;
      underflow <= read && empty;
    end
endmodule

// File: tb/tb_bus_fifo.sv
// tb_bus_fifo: vector table, hand sequences and random traffic against a queue model
module tb_bus_fifo;
  logic       clock, reset, load, read;
  logic [7:0] in, out;
  logic       empty, full, overflow, underflow;
  logic [2:0] count;
  int total, bad;
  typedef struct {
    logic       ld, rd;
    logic [7:0] din, eout;
    logic [2:0] ecnt;
    logic       eovf, eunf;
  } vec_t;
  vec_t vec[$];
  logic [7:0] q[$];
  logic movf, munf;

  bus_fifo #(.BUS_WIDTH(8), .DEPTH(4)) dut (
    .clock(clock), .reset(reset), .in(in), .load(load), .read(read),
    .out(out), .empty(empty), .full(full), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // reference: a plain queue of words, rules applied to pre-edge occupancy
  task automatic model(input logic l, input logic r, input logic [7:0] d);
    bit was_full = q.size() == 4;
    bit was_empty = q.size() == 0;
    bit w = l && (!was_full || r);
    bit p = r && !was_empty;
    if (p) void'(q.pop_front());
    if (w) q.push_back(d);
    movf = l && !w;
    munf = r && was_empty;
  endtask

  task automatic apply(input logic l, input logic r, input logic [7:0] d);
    load = l; read = r; in = d;
    @(posedge clock);
    @(negedge clock);
    model(l, r, d);
    load = 0; read = 0;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".out"}, out, q.size() != 0 ? q[0] : 8'd0);
    chk({tag, ".count"}, count, q.size());
    chk({tag, ".empty"}, empty, q.size() == 0);
    chk({tag, ".full"}, full, q.size() == 4);
    chk({tag, ".overflow"}, overflow, movf);
    chk({tag, ".underflow"}, underflow, munf);
  endtask

  task automatic add(input logic l, r, input logic [7:0] d, e, input logic [2:0] c, input logic o, u);
    vec.push_back('{ld: l, rd: r, din: d, eout: e, ecnt: c, eovf: o, eunf: u});
  endtask

  task automatic fill9;
    add(1, 0, 9, 9, 1, 0, 0);
    add(1, 0, 10, 9, 2, 0, 0);
    add(1, 0, 11, 9, 3, 0, 0);
    add(1, 0, 12, 9, 4, 0, 0);
  endtask

  initial begin
    total = 0; bad = 0;
    load = 0; read = 0; in = 0; movf = 0; munf = 0;
    reset = 1;
    #12 reset = 0;
    repeat (3) @(negedge clock);
    chk("rst.empty", empty, 1);
    chk("rst.full", full, 0);
    chk("rst.count", count, 0);
    chk("rst.out", out, 0);
    chk("rst.overflow", overflow, 0);
    chk("rst.underflow", underflow, 0);
    fill9;
    add(0, 1, 0, 10, 3, 0, 0);
    add(0, 1, 0, 11, 2, 0, 0);
    add(0, 1, 0, 12, 1, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0);
    fill9;
    add(1, 0, 99, 9, 4, 1, 0);
    add(0, 0, 0, 9, 4, 0, 0);
    add(0, 1, 0, 10, 3, 0, 0);
    add(0, 1, 0, 11, 2, 0, 0);
    add(0, 1, 0, 12, 1, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 5, 5, 1, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0);
    fill9;
    add(1, 1, 13, 10, 4, 0, 0);
    add(0, 1, 0, 11, 3, 0, 0);
    add(0, 1, 0, 12, 2, 0, 0);
    add(0, 1, 0, 13, 1, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0);
    add(1, 1, 7, 7, 1, 0, 1);
    add(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < vec.size(); i++) begin
      apply(vec[i].ld, vec[i].rd, vec[i].din);
      chk($sformatf("vec%0d.out", i), out, vec[i].eout);
      chk($sformatf("vec%0d.count", i), count, vec[i].ecnt);
      chk($sformatf("vec%0d.full", i), full, vec[i].ecnt == 3'd4);
      chk($sformatf("vec%0d.empty", i), empty, vec[i].ecnt == 3'd0);
      chk($sformatf("vec%0d.overflow", i), overflow, vec[i].eovf);
      chk($sformatf("vec%0d.underflow", i), underflow, vec[i].eunf);
    end
    for (int i = 1; i <= 10; i++) begin
      apply(1, 0, 8'(i));
      chk("wrap.out", out, i);
      chk("wrap.count1", count, 1);
      apply(0, 1, 0);
      chk("wrap.count0", count, 0);
      chk("wrap.empty", empty, 1);
    end
    apply(1, 0, 21);
    apply(1, 0, 22);
    apply(1, 0, 23);
    chk("pre_rst.count", count, 3);
    #2 reset = 1;
    #1;
    chk("midrst.count", count, 0);
    chk("midrst.empty", empty, 1);
    chk("midrst.out", out, 0);
    #1 reset = 0;
    q.delete(); movf = 0; munf = 0;
    @(negedge clock);
    apply(1, 0, 42);
    chk("postrst.out", out, 42);
    chk("postrst.count", count, 1);
    for (int i = 0; i < 400; i++) begin
      int bias = ((i / 40) % 2) ? 30 : 70;
      apply($urandom_range(0, 99) < bias, $urandom_range(0, 99) >= bias, 8'($urandom));
      chk_model("rand");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
